// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one uart_tx; define UART_ARB_TIMEOUT_EN to revoke silent owners
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   byte_valid,
  input  logic [8*N_REQ-1:0] byte_data,
  output logic [N_REQ-1:0]   byte_ready,
  output logic [N_REQ-1:0]   gnt,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               arb_busy,
  output logic               timeout_err
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, WAIT_ACK = 2'd2, WAIT_DONE = 2'd3;
  logic [1:0]    state;
  logic [1:0]    ack_cnt;
  logic [IW-1:0] own, rr_ptr, pick, idx, nxt;
  logic [7:0]    own_byte;
  logic          found, own_req, hs, rel, to_hit;
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % N_REQ);
      if (req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  always_comb begin
    own_byte = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) own_byte = byte_data[8*i +: 8];
  end
  assign own_req    = |(gnt & req);
  assign byte_ready = (state == GRANT && !tx_busy) ? gnt & byte_valid : '0;
  assign hs         = |byte_ready;
  assign nxt        = (own == IW'(N_REQ-1)) ? '0 : own + IW'(1);
  assign arb_busy   = state != IDLE;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] to_cnt;
  assign to_hit = state == GRANT && !(|(gnt & byte_valid)) && to_cnt == TW'(TIMEOUT_CYC-1);
  always_ff @(posedge clk)
    if (rst || hs || state != GRANT) to_cnt <= '0;
    else if (!(|(gnt & byte_valid))) to_cnt <= to_cnt + TW'(1);
`else
  assign to_hit = 1'b0;
`endif
  assign rel = (state == GRANT && !hs && (!own_req || to_hit)) ||
               (state == WAIT_DONE && !tx_busy && !own_req);
  always_ff @(posedge clk) begin
    tx_start <= 1'b0;
    timeout_err <= 1'b0;
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      own <= '0;
      rr_ptr <= '0;
      tx_data <= '0;
      ack_cnt <= '0;
    end else if (rel) begin
      state <= IDLE;
      gnt <= '0;
      rr_ptr <= nxt;
      timeout_err <= to_hit && own_req;
    end else if (state == IDLE && found) begin
      state <= GRANT;
      gnt <= N_REQ'(1) << pick;
      own <= pick;
    end else if (hs) begin
      tx_data <= own_byte;
      tx_start <= 1'b1;
      state <= WAIT_ACK;
      ack_cnt <= '0;
    end else if (state == WAIT_ACK && (tx_busy || ack_cnt == 2'd3)) begin
      state <= WAIT_DONE;
    end else if (state == WAIT_ACK) begin
      ack_cnt <= ack_cnt + 2'd1;
    end else if (state == WAIT_DONE && !tx_busy) begin
      state <= GRANT;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests with a round-robin/scoreboard model checked every cycle
module tb_uart_tx_arbiter;
  localparam int FRAME = 5;
  logic        clk = 1'b0, rst = 1'b1, tx_busy = 1'b0;
  logic [3:0]  req = '0, byte_valid = '0;
  logic [31:0] byte_data = '0;
  logic [3:0]  byte_ready, gnt;
  logic [7:0]  tx_data;
  logic        tx_start, arb_busy, timeout_err;
  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .gnt(gnt), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int nchk = 0, nerr = 0, cyc = 0, busy_left = 0;
  logic [7:0] pbuf [4][8];
  int ph [4] = '{0, 0, 0, 0};
  int pt [4] = '{0, 0, 0, 0};
  logic [7:0] exp_q [$];
  int g_cyc [$], g_idx [$];
  logic [3:0] hs_vec = '0;
  logic start_seen = 1'b0, mute = 1'b0, fair = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p+i)%4]) return (p+i)%4;
    return 0;
  endfunction
  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      byte_valid[i] = ph[i] < pt[i];
      byte_data[8*i +: 8] = byte_valid[i] ? pbuf[i][ph[i]] : 8'h00;
    end
  endtask
  task automatic push(input int p, input logic [7:0] b, input logic expect_tx);
    pbuf[p][pt[p]] = b;
    pt[p]++;
    if (expect_tx) exp_q.push_back(b);
    drive();
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (start_seen) busy_left = FRAME;
    else if (busy_left > 0) busy_left--;
    tx_busy = busy_left > 0 && !mute;
    for (int i = 0; i < 4; i++)
      if (hs_vec[i] && !rst) begin
        ph[i]++;
        if (fair) req[i] = 1'b0;
      end
    if (fair)
      for (int i = 0; i < 4; i++)
        if (!gnt[i] && !req[i] && ph[i] < pt[i]) req[i] = 1'b1;
    drive();
  endtask
  // Spec-level model: rr pointer follows releases, one byte in flight until the UART goes idle
  logic [3:0] p_gnt = '0, p_req = '0, p_hs = '0;
  logic       p_rst = 1'b1, p_busy = 1'b0, inflight = 1'b0, seen_busy = 1'b0;
  logic [7:0] p_data = '0;
  int         ptr = 0;
  always @(negedge clk) begin
    cyc++;
    if (p_rst) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_ready", byte_ready, 0);
      chk("rst_start", tx_start, 0);
      chk("rst_arb_busy", arb_busy, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_timeout_err", timeout_err, 0);
      ptr = 0;
      inflight = 1'b0;
      seen_busy = 1'b0;
    end else begin
      chk("one_in_flight", inflight && p_hs != 0 && !mute, 0);
      if (p_hs != 0) begin
        inflight = 1'b1;
        seen_busy = 1'b0;
      end else if (mute) inflight = 1'b0;
      else if (inflight && seen_busy && !p_busy) inflight = 1'b0;
      if (inflight && tx_busy) seen_busy = 1'b1;
      chk("arb_busy", arb_busy, gnt != 0);
      chk("start_after_hs", tx_start, p_hs != 0);
      chk("ready_subset", byte_ready & ~(gnt & byte_valid), 0);
      if (!mute) chk("byte_ready", byte_ready, inflight ? 4'b0 : gnt & byte_valid & {4{~tx_busy}});
      if (!tx_start) chk("tx_data_hold", tx_data, p_data);
      else begin
        chk("tx_queued", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("tx_data", tx_data, exp_q.pop_front());
      end
      if (p_gnt == 0) chk("grant", gnt, p_req == 0 ? 32'd0 : 32'd1 << rr_pick(p_req, ptr));
      else if (gnt != 0) chk("grant_held", gnt, p_gnt);
      else begin
        chk("release_legal", (p_req & p_gnt) == 0 || timeout_err, 1);
        chk("release_idle", inflight, 0);
        ptr = (idx_of(p_gnt) + 1) % 4;
      end
      if (p_gnt == 0 && gnt != 0) begin
        g_cyc.push_back(cyc);
        g_idx.push_back(idx_of(gnt));
      end
`ifdef UART_ARB_TIMEOUT_EN
      chk("terr_only_on_release", timeout_err && !(p_gnt != 0 && gnt == 0), 0);
`else
      chk("terr_zero", timeout_err, 0);
`endif
    end
    p_gnt = gnt;
    p_req = req;
    p_hs = byte_ready & byte_valid;
    p_rst = rst;
    p_busy = tx_busy;
    p_data = tx_data;
    hs_vec = p_hs;
    start_seen = tx_start;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  int ord [5] = '{0, 1, 2, 3, 0};
  int zc, rc, n;
  initial begin
    tick();
    tick();
    rst = 1'b0;
    // 1: single owner, two bytes, then pointer moves to 1
    push(0, 8'h41, 1'b1);
    push(0, 8'h42, 1'b1);
    req = 4'b0001;
    chk("t1_gnt_before", gnt, 4'b0000);
    tick();
    chk("t1_gnt", gnt, 4'b0001);
    for (int k = 0; k < 60 && ph[0] != 2; k++) tick();
    chk("t1_bytes_taken", ph[0], 2);
    req = 4'b0000;
    for (int k = 0; k < 40 && gnt != 0; k++) tick();
    chk("t1_release", gnt, 4'b0000);
    req = 4'b1001;
    tick();
    chk("t1_ptr_is_1", gnt, 4'b1000);
    req = 4'b0000;
    for (int k = 0; k < 10 && gnt != 0; k++) tick();
    // 2: simultaneous 0 and 2 from pointer 0
    push(0, 8'h10, 1'b1);
    push(0, 8'h11, 1'b1);
    push(2, 8'h20, 1'b1);
    req = 4'b0101;
    tick();
    chk("t2_first", gnt, 4'b0001);
    for (int k = 0; k < 60 && ph[0] != 4; k++) tick();
    req = 4'b0100;
    zc = 0;
    for (int k = 0; k < 40 && gnt != 4'b0100; k++) begin
      tick();
      if (gnt == 0) zc++;
    end
    chk("t2_second", gnt, 4'b0100);
    chk("t2_idle_cycles", zc, 1);
    for (int k = 0; k < 40 && ph[2] != 1; k++) tick();
    req = 4'b0000;
    for (int k = 0; k < 40 && gnt != 0; k++) tick();
    chk("t2_drained", gnt, 4'b0000);
    // 3: fairness from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    g_cyc.delete();
    g_idx.delete();
    push(0, 8'h30, 1'b1);
    push(1, 8'h31, 1'b1);
    push(2, 8'h32, 1'b1);
    push(3, 8'h33, 1'b1);
    push(0, 8'h34, 1'b1);
    fair = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 120 && ph[0] != 6; k++) tick();
    fair = 1'b0;
    req = 4'b0000;
    for (int k = 0; k < 40 && gnt != 0; k++) tick();
    chk("t3_grants", g_idx.size(), 5);
    if (g_idx.size() >= 5)
      for (int k = 0; k < 5; k++) begin
        chk("t3_order", g_idx[k], ord[k]);
        if (k < 4) chk("t3_spacing", g_cyc[k+1] - g_cyc[k], 9);
      end
    // 4: req drops with the handshake of 0x7F
    push(1, 8'h7F, 1'b1);
    req = 4'b0010;
    tick();
    chk("t4_gnt", gnt, 4'b0010);
    chk("t4_ready", byte_ready, 4'b0010);
    req = 4'b0000;
    push(1, 8'h80, 1'b0);
    rc = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (byte_ready[1]) rc++;
    end
    chk("t4_no_more_ready", rc, 0);
    chk("t4_released", gnt, 4'b0000);
    ph[1] = pt[1];
    drive();
    // 5: reset during WAIT_DONE
    push(2, 8'h55, 1'b1);
    req = 4'b0100;
    for (int k = 0; k < 20 && !tx_busy; k++) tick();
    chk("t5_busy_seen", tx_busy, 1);
    tick();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    chk("t5_gnt", gnt, 4'b0000);
    chk("t5_start", tx_start, 0);
    chk("t5_arb_busy", arb_busy, 0);
    push(1, 8'h66, 1'b1);
    req = 4'b0110;
    tick();
    chk("t5_ptr_is_0", gnt, 4'b0010);
    for (int k = 0; k < 40 && ph[1] != pt[1]; k++) tick();
    req = 4'b0000;
    for (int k = 0; k < 40 && gnt != 0; k++) tick();
    // 6: silent owner 2 with port 3 pending
    req = 4'b1100;
    tick();
    chk("t6_gnt", gnt, 4'b0100);
`ifdef UART_ARB_TIMEOUT_EN
    rc = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (timeout_err) rc++;
    end
    chk("t6_no_early_timeout", rc, 0);
    tick();
    chk("t6_timeout_err", timeout_err, 1);
    chk("t6_revoked", gnt, 4'b0000);
    tick();
    chk("t6_next_owner", gnt, 4'b1000);
`else
    for (int k = 0; k < 40; k++) tick();
    chk("t6_still_owned", gnt, 4'b0100);
`endif
    req = 4'b0000;
    for (int k = 0; k < 10 && gnt != 0; k++) tick();
    chk("t6_released", gnt, 4'b0000);
    // 7: UART never acknowledges; ack wait gives up after 4 cycles
    mute = 1'b1;
    push(3, 8'h99, 1'b1);
    push(3, 8'h9A, 1'b1);
    req = 4'b1000;
    for (int k = 0; k < 20 && !tx_start; k++) tick();
    chk("t7_start", tx_start, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!byte_ready[3] && n < 20);
    chk("t7_ack_timeout", n, 5);
    for (int k = 0; k < 20 && ph[3] != pt[3]; k++) tick();
    req = 4'b0000;
    for (int k = 0; k < 20 && gnt != 0; k++) tick();
    for (int k = 0; k < 8; k++) tick();
    mute = 1'b0;
    chk("end_idle", arb_busy, 0);
    chk("exp_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
